pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/types_pkg.sv | 29 ++
 rtl/sat_counter16.sv | 23 ++
 rtl/pipeline_control.sv | 137 +++++++++++++
 tb/tb_pipeline_control.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : types_pkg
// Description : Shared widths, controller state encoding and hazard helper
//               for the pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package types_pkg;

    localparam int ADDRESS_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } CTRL_STATE;

    // x0 is hard-wired to zero, so a load targeting it can never hazard.
    function automatic logic loadUseHazard(
        input logic                     resultSrcE,
        input logic [ADDRESS_WIDTH-1:0] rdE,
        input logic [ADDRESS_WIDTH-1:0] rs1D,
        input logic [ADDRESS_WIDTH-1:0] rs2D
    );
        return resultSrcE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter16
// Description : 16-bit event counter that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_control
// Description : Stall/flush controller for a 5-stage pipeline with memory
//               wait tracking, timeout fault and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control
    import types_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D_i,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D_i,
    input  logic [ADDRESS_WIDTH-1:0] RdE_i,
    input  logic                     ResultSrcE_i,
    input  logic                     PCSrcE_i,
    input  logic                     MemReqM_i,
    input  logic                     MemReadyM_i,
    output logic                     StallF_o,
    output logic                     StallD_o,
    output logic                     StallE_o,
    output logic                     StallM_o,
    output logic                     FlushD_o,
    output logic                     FlushE_o,
    output logic                     FlushW_o,
    output logic [1:0]               State_o,
    output logic                     Fault_o,
    output logic [15:0]              StallCnt_o,
    output logic [15:0]              FlushCnt_o
);

    localparam logic [8:0] c_WAIT_LIMIT = 9'(WAIT_LIMIT);

    CTRL_STATE  r_state;
    CTRL_STATE  w_nextState;
    logic [7:0] r_waitCnt;
    logic [7:0] w_nextWaitCnt;
    logic [8:0] w_waitCntInc;
    logic       w_memStall;
    logic       w_hazard;
    logic       w_stallAll;
    logic       w_stallFD;
    logic       w_flushD;
    logic       w_flushE;
    logic       w_branchEvt;

    assign w_memStall   = MemReqM_i && !MemReadyM_i;
    assign w_hazard     = loadUseHazard(ResultSrcE_i, RdE_i, Rs1D_i, Rs2D_i);
    assign w_waitCntInc = {1'b0, r_waitCnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_waitCnt <= 8'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_stallAll    = 1'b0;
        w_stallFD     = 1'b0;
        w_flushD      = 1'b0;
        w_flushE      = 1'b0;
        w_branchEvt   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_memStall) begin
                    w_stallAll    = 1'b1;
                    w_nextState   = MEM_WAIT;
                    w_nextWaitCnt = 8'd1;
                end else if (PCSrcE_i) begin
                    w_flushD    = 1'b1;
                    w_flushE    = 1'b1;
                    w_branchEvt = 1'b1;
                end else if (w_hazard) begin
                    w_stallFD = 1'b1;
                    w_flushE  = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Ready only counts while the Memory stage is actually requesting.
                if (MemReqM_i && MemReadyM_i) begin
                    w_nextState   = RUN;
                    w_nextWaitCnt = 8'd0;
                end else begin
                    w_stallAll = 1'b1;
                    if (w_waitCntInc >= c_WAIT_LIMIT) begin
                        w_nextState = FAULT;
                    end else begin
                        w_nextWaitCnt = w_waitCntInc[7:0];
                    end
                end
            end
            FAULT: begin
                w_stallAll = 1'b1;
            end
            default: begin
                w_nextState   = RUN;
                w_nextWaitCnt = 8'd0;
            end
        endcase
    end

    // Outputs are gated by rst_n so inputs cannot leak through while in reset.
    assign StallF_o = rst_n && (w_stallAll || w_stallFD);
    assign StallD_o = rst_n && (w_stallAll || w_stallFD);
    assign StallE_o = rst_n && w_stallAll;
    assign StallM_o = rst_n && w_stallAll;
    assign FlushD_o = rst_n && w_flushD;
    assign FlushE_o = rst_n && w_flushE;
    assign FlushW_o = rst_n && w_stallAll;
    assign State_o  = r_state;
    assign Fault_o  = (r_state == FAULT);

    sat_counter16 u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF_o),
        .count (StallCnt_o)
    );

    sat_counter16 u_flushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n && w_branchEvt),
        .count (FlushCnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_control
// Description : Directed self-checking bench for pipeline_control (WAIT_LIMIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_control;

    localparam logic [6:0] c_NONE      = 7'b0000000;
    localparam logic [6:0] c_STALL_ALL = 7'b1111001;
    localparam logic [6:0] c_LOAD_USE  = 7'b1100010;
    localparam logic [6:0] c_BRANCH    = 7'b0000110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  Rs1D = 5'd0;
    logic [4:0]  Rs2D = 5'd0;
    logic [4:0]  RdE = 5'd0;
    logic        ResultSrcE = 1'b0;
    logic        PCSrcE = 1'b0;
    logic        MemReqM = 1'b0;
    logic        MemReadyM = 1'b0;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Fault;
    logic [1:0]  State;
    logic [15:0] StallCnt, FlushCnt;
    logic [6:0]  ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    pipeline_control #(.WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs1D_i       (Rs1D),
        .Rs2D_i       (Rs2D),
        .RdE_i        (RdE),
        .ResultSrcE_i (ResultSrcE),
        .PCSrcE_i     (PCSrcE),
        .MemReqM_i    (MemReqM),
        .MemReadyM_i  (MemReadyM),
        .StallF_o     (StallF),
        .StallD_o     (StallD),
        .StallE_o     (StallE),
        .StallM_o     (StallM),
        .FlushD_o     (FlushD),
        .FlushE_o     (FlushE),
        .FlushW_o     (FlushW),
        .State_o      (State),
        .Fault_o      (Fault),
        .StallCnt_o   (StallCnt),
        .FlushCnt_o   (FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
        ResultSrcE = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; idle();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        @(negedge clk); MemReqM = 1'b1;
        repeat (2) @(negedge clk);
        // Drop reset mid-wait with every hazard input active.
        rst_n = 1'b0; PCSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        #1;
        checks++; if (ctl !== c_NONE) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, c_NONE); end
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
        checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", Fault); end
        checks++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", StallCnt, FlushCnt); end
        @(negedge clk); rst_n = 1'b1; idle(); #1;
        checks++; if (ctl !== c_NONE || State !== 2'd0) begin errors++; $display("FAIL reset_release: got ctl %b state %0d want 0000000 0", ctl, State); end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd3; #1;
        checks++; if (ctl !== c_LOAD_USE) begin errors++; $display("FAIL load_use_ctl: got %b want %b", ctl, c_LOAD_USE); end
        @(negedge clk); idle(); #1;
        checks++; if (ctl !== c_NONE) begin errors++; $display("FAIL load_use_release: got %b want %b", ctl, c_NONE); end
        checks++; if (StallCnt !== 16'd1) begin errors++; $display("FAIL load_use_stallcnt: got %0d want 1", StallCnt); end
        checks++; if (FlushCnt !== 16'd0) begin errors++; $display("FAIL load_use_flushcnt: got %0d want 0", FlushCnt); end
    endtask

    task automatic test_x0();
        do_reset();
        @(negedge clk); ResultSrcE = 1'b1; RdE = 5'd0; Rs1D = 5'd4; Rs2D = 5'd0; #1;
        checks++; if (ctl !== c_NONE) begin errors++; $display("FAIL x0_ctl: got %b want %b", ctl, c_NONE); end
        @(negedge clk); idle(); #1;
        checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL x0_stallcnt: got %0d want 0", StallCnt); end
    endtask

    task automatic test_branch_and_hazard();
        do_reset();
        @(negedge clk); PCSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; #1;
        checks++; if (ctl !== c_BRANCH) begin errors++; $display("FAIL branch_ctl: got %b want %b", ctl, c_BRANCH); end
        @(negedge clk); idle(); #1;
        checks++; if (FlushCnt !== 16'd1) begin errors++; $display("FAIL branch_flushcnt: got %0d want 1", FlushCnt); end
        checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL branch_stallcnt: got %0d want 0", StallCnt); end
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge clk); MemReqM = 1'b1; PCSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd9; Rs1D = 5'd9; #1;
        checks++; if (ctl !== c_STALL_ALL) begin errors++; $display("FAIL priority_ctl: got %b want %b", ctl, c_STALL_ALL); end
        @(negedge clk); idle(); #1;
        checks++; if (FlushCnt !== 16'd0 || State !== 2'd1) begin errors++; $display("FAIL priority_after: got flushcnt %0d state %0d want 0 1", FlushCnt, State); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b0; #1;
        checks++; if (ctl !== c_STALL_ALL || State !== 2'd0) begin errors++; $display("FAIL memwait_c1: got ctl %b state %0d want %b 0", ctl, State, c_STALL_ALL); end
        @(negedge clk); #1;
        checks++; if (ctl !== c_STALL_ALL || State !== 2'd1) begin errors++; $display("FAIL memwait_c2: got ctl %b state %0d want %b 1", ctl, State, c_STALL_ALL); end
        // Ready without a request must not end the wait.
        @(negedge clk); MemReqM = 1'b0; MemReadyM = 1'b1; #1;
        checks++; if (ctl !== c_STALL_ALL || State !== 2'd1) begin errors++; $display("FAIL memwait_noreq: got ctl %b state %0d want %b 1", ctl, State, c_STALL_ALL); end
        @(negedge clk); MemReqM = 1'b1; PCSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; #1;
        checks++; if (ctl !== c_NONE || State !== 2'd1) begin errors++; $display("FAIL memwait_ready: got ctl %b state %0d want %b 1", ctl, State, c_NONE); end
        @(negedge clk); idle(); #1;
        checks++; if (State !== 2'd0 || ctl !== c_NONE) begin errors++; $display("FAIL memwait_run: got state %0d ctl %b want 0 %b", State, ctl, c_NONE); end
        checks++; if (StallCnt !== 16'd3 || FlushCnt !== 16'd0) begin errors++; $display("FAIL memwait_cnt: got %0d/%0d want 3/0", StallCnt, FlushCnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (State !== 2'd1 || Fault !== 1'b0) begin errors++; $display("FAIL timeout_before: got state %0d fault %b want 1 0", State, Fault); end
        @(negedge clk); #1;
        checks++; if (State !== 2'd2 || Fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got state %0d fault %b want 2 1", State, Fault); end
        checks++; if (ctl !== c_STALL_ALL || StallCnt !== 16'd4) begin errors++; $display("FAIL timeout_outputs: got ctl %b stallcnt %0d want %b 4", ctl, StallCnt, c_STALL_ALL); end
        MemReadyM = 1'b1;
        @(negedge clk); #1;
        checks++; if (State !== 2'd2 || ctl !== c_STALL_ALL || StallCnt !== 16'd5) begin errors++; $display("FAIL timeout_absorbing: got state %0d ctl %b stallcnt %0d want 2 %b 5", State, ctl, StallCnt, c_STALL_ALL); end
        rst_n = 1'b0; #1;
        checks++; if (State !== 2'd0 || Fault !== 1'b0 || StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin errors++; $display("FAIL timeout_reset: got state %0d fault %b cnt %0d/%0d want 0 0 0/0", State, Fault, StallCnt, FlushCnt); end
        @(negedge clk); rst_n = 1'b1; idle();
        @(negedge clk); #1;
        checks++; if (ctl !== c_NONE || State !== 2'd0 || StallCnt !== 16'd0) begin errors++; $display("FAIL timeout_release: got ctl %b state %0d stallcnt %0d want %b 0 0", ctl, State, StallCnt, c_NONE); end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (70000) @(negedge clk);
        #1;
        checks++; if (StallCnt !== 16'hFFFF) begin errors++; $display("FAIL sat_stallcnt: got %h want ffff", StallCnt); end
        checks++; if (FlushCnt !== 16'h0000 || State !== 2'd2) begin errors++; $display("FAIL sat_other: got flushcnt %h state %0d want 0000 2", FlushCnt, State); end
        do_reset();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_load_use();
        test_x0();
        test_branch_and_hazard();
        test_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
